perf_counter_bank: RTL and testbench

Event-counter bank that produces the eight 32-bit performance counters read back through the low 32-byte memory-mapped counter window (word index = address[4:2]).

---
 rtl/perf_counter_bank.sv | 88 ++++++++
 tb/tb_perf_counter_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Eight saturating event counters (I/D/L1 port accesses and busy cycles, branches) with store-to-clear.
// Latency: events at edge n are visible after edge n; no input-to-output combinational path.
module perf_counter_bank #(
    parameter int CNT_WIDTH    = 32,
    parameter int WINDOW_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic        instr_resp,
    input  logic        data_read,
    input  logic        data_write,
    input  logic        data_resp,
    input  logic        l1_read,
    input  logic        l1_write,
    input  logic        l1_resp,
    input  logic        br_valid,
    input  logic        br_mispredict,
    input  logic        pipe_advance,
    input  logic        ctr_store,
    input  logic [31:0] ctr_addr,
    output logic [31:0] num_instr_access,
    output logic [31:0] num_data_access,
    output logic [31:0] num_l1_access,
    output logic [31:0] instr_cycles,
    output logic [31:0] data_cycles,
    output logic [31:0] l1_cycles,
    output logic [31:0] num_predictions,
    output logic [31:0] num_mispredictions
);

    typedef enum logic {IDLE, BUSY} port_state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    port_state_t          state [3];
    logic [CNT_WIDTH-1:0] cnt   [8];
    logic [2:0]           req;
    logic [2:0]           resp;
    logic [7:0]           inc;
    logic                 clear_hit;
    logic [2:0]           clear_idx;

    // Port order matches counter order: 0 = I-cache, 1 = D-cache, 2 = L1.
    assign req  = {l1_read | l1_write, data_read | data_write, instr_read};
    assign resp = {l1_resp, data_resp, instr_resp};

    // A new access is only counted from IDLE; every requesting cycle is a busy cycle.
    always_comb begin
        inc = '0;
        for (int p = 0; p < 3; p++) begin
            inc[p]     = req[p] && (state[p] == IDLE);
            inc[p + 3] = req[p];
        end
        inc[6] = br_valid & pipe_advance;
        inc[7] = br_valid & br_mispredict & pipe_advance;
    end

    assign clear_hit = ctr_store & pipe_advance & (ctr_addr < 32'(WINDOW_BYTES));
    assign clear_idx = ctr_addr[4:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 3; p++) state[p] <= IDLE;
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
        end else begin
            // Stay BUSY only while the request is held and no response has arrived.
            for (int p = 0; p < 3; p++)
                state[p] <= (req[p] && !resp[p]) ? BUSY : IDLE;
            for (int i = 0; i < 8; i++) begin
                if (clear_hit && clear_idx == 3'(i))
                    cnt[i] <= '0;
                else if (inc[i] && cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    assign num_instr_access   = 32'(cnt[0]);
    assign num_data_access    = 32'(cnt[1]);
    assign num_l1_access      = 32'(cnt[2]);
    assign instr_cycles       = 32'(cnt[3]);
    assign data_cycles        = 32'(cnt[4]);
    assign l1_cycles          = 32'(cnt[5]);
    assign num_predictions    = 32'(cnt[6]);
    assign num_mispredictions = 32'(cnt[7]);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: directed scenarios plus random traffic against a behavioural model.
// Two instances (32-bit and 4-bit counters) share stimulus so saturation is reached quickly.
module tb_perf_counter_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_read, instr_resp;
    logic        data_read, data_write, data_resp;
    logic        l1_read, l1_write, l1_resp;
    logic        br_valid, br_mispredict, pipe_advance;
    logic        ctr_store;
    logic [31:0] ctr_addr;

    logic [7:0][31:0] o32;
    logic [7:0][31:0] o4;

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    always #5 clk = ~clk;

    perf_counter_bank #(.CNT_WIDTH(32), .WINDOW_BYTES(32)) dut (
        .clk(clk), .rst(rst),
        .instr_read(instr_read), .instr_resp(instr_resp),
        .data_read(data_read), .data_write(data_write), .data_resp(data_resp),
        .l1_read(l1_read), .l1_write(l1_write), .l1_resp(l1_resp),
        .br_valid(br_valid), .br_mispredict(br_mispredict), .pipe_advance(pipe_advance),
        .ctr_store(ctr_store), .ctr_addr(ctr_addr),
        .num_instr_access(o32[0]), .num_data_access(o32[1]), .num_l1_access(o32[2]),
        .instr_cycles(o32[3]), .data_cycles(o32[4]), .l1_cycles(o32[5]),
        .num_predictions(o32[6]), .num_mispredictions(o32[7])
    );

    perf_counter_bank #(.CNT_WIDTH(4), .WINDOW_BYTES(32)) dut_small (
        .clk(clk), .rst(rst),
        .instr_read(instr_read), .instr_resp(instr_resp),
        .data_read(data_read), .data_write(data_write), .data_resp(data_resp),
        .l1_read(l1_read), .l1_write(l1_write), .l1_resp(l1_resp),
        .br_valid(br_valid), .br_mispredict(br_mispredict), .pipe_advance(pipe_advance),
        .ctr_store(ctr_store), .ctr_addr(ctr_addr),
        .num_instr_access(o4[0]), .num_data_access(o4[1]), .num_l1_access(o4[2]),
        .instr_cycles(o4[3]), .data_cycles(o4[4]), .l1_cycles(o4[5]),
        .num_predictions(o4[6]), .num_mispredictions(o4[7])
    );

    // Reference model: m[0] for 32-bit counters, m[1] for 4-bit counters.
    longint unsigned m [2][8];
    longint unsigned mx [2] = '{64'hFFFF_FFFF, 64'd15};
    bit outstanding [3];

    always @(posedge clk) begin
        bit rq [3];
        bit rs [3];
        bit ev [8];
        bit clr;
        int idx;
        rq = '{instr_read, data_read | data_write, l1_read | l1_write};
        rs = '{instr_resp, data_resp, l1_resp};
        if (rst) begin
            for (int w = 0; w < 2; w++) for (int i = 0; i < 8; i++) m[w][i] = 0;
            for (int p = 0; p < 3; p++) outstanding[p] = 1'b0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                ev[p]     = rq[p] && !outstanding[p];
                ev[p + 3] = rq[p];
                outstanding[p] = rq[p] && !rs[p];
            end
            ev[6] = br_valid && pipe_advance;
            ev[7] = br_valid && br_mispredict && pipe_advance;
            clr = ctr_store && pipe_advance && (ctr_addr < 32);
            idx = int'(ctr_addr % 32) / 4;
            for (int w = 0; w < 2; w++)
                for (int i = 0; i < 8; i++) begin
                    if (clr && idx == i) m[w][i] = 0;
                    else if (ev[i] && m[w][i] < mx[w]) m[w][i] = m[w][i] + 1;
                end
        end
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("w32 ctr%0d", i), longint'(o32[i]), m[0][i]);
                chk($sformatf("w4 ctr%0d", i), longint'(o4[i]), m[1][i]);
            end
        end
    end

    // Pins both the DUT and the model to a hand-computed value.
    task automatic lit(input string name, input int i, input longint unsigned exp32, input longint unsigned exp4);
        chk({name, " dut32"}, longint'(o32[i]), exp32);
        chk({name, " model32"}, m[0][i], exp32);
        chk({name, " dut4"}, longint'(o4[i]), exp4);
    endtask

    task automatic idle_inputs();
        instr_read = 0; instr_resp = 0;
        data_read = 0; data_write = 0; data_resp = 0;
        l1_read = 0; l1_write = 0; l1_resp = 0;
        br_valid = 0; br_mispredict = 0; pipe_advance = 0;
        ctr_store = 0; ctr_addr = 32'h0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick(2);
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 8; i++) lit($sformatf("reset ctr%0d", i), i, 0, 0);

        // I-cache: request held 4 cycles, response on the 4th.
        instr_read = 1; tick(3);
        instr_resp = 1; tick(1);
        idle_inputs(); tick(1);
        lit("instr_access", 0, 1, 1);
        lit("instr_cycles", 3, 4, 4);

        // D-cache: single-cycle read, then back-to-back 3-cycle write.
        data_read = 1; data_resp = 1; tick(1);
        data_read = 0; data_resp = 0; data_write = 1; tick(2);
        data_resp = 1; tick(1);
        idle_inputs(); tick(1);
        lit("data_access", 1, 2, 2);
        lit("data_cycles", 4, 4, 4);

        // L1: aborted 2-cycle read, then a single-cycle read.
        l1_read = 1; tick(2);
        l1_read = 0; tick(2);
        l1_read = 1; l1_resp = 1; tick(1);
        idle_inputs(); tick(1);
        lit("l1_access", 2, 2, 2);
        lit("l1_cycles", 5, 3, 3);

        // Branches: a stalled mispredict counted once, then a correct branch.
        br_valid = 1; br_mispredict = 1; tick(2);
        pipe_advance = 1; tick(1);
        br_mispredict = 0; tick(1);
        idle_inputs(); tick(1);
        lit("predictions", 6, 2, 2);
        lit("mispredictions", 7, 1, 1);

        // Clear data_cycles in the same cycle it increments; store to 0x20 is ignored.
        data_read = 1; tick(1);
        ctr_store = 1; pipe_advance = 1; ctr_addr = 32'h10; tick(1);
        idle_inputs(); tick(1);
        ctr_store = 1; pipe_advance = 1; ctr_addr = 32'h20; tick(1);
        idle_inputs(); tick(1);
        lit("clr data_cycles", 4, 0, 0);
        lit("clr data_access", 1, 3, 3);
        lit("clr instr_access", 0, 1, 1);
        lit("clr instr_cycles", 3, 4, 4);
        lit("clr l1_access", 2, 2, 2);
        lit("clr predictions", 6, 2, 2);

        // Saturation: 16 more single-cycle L1 accesses push the 4-bit counter to its limit.
        l1_write = 1; l1_resp = 1; tick(16);
        idle_inputs(); tick(1);
        lit("sat l1_access", 2, 18, 15);
        lit("sat l1_cycles", 5, 19, 15);
        ctr_store = 1; pipe_advance = 1; ctr_addr = 32'h8; tick(1);
        idle_inputs(); tick(1);
        lit("sat clear", 2, 0, 0);

        // Reset during a BUSY I-cache transaction; later stray response is ignored.
        instr_read = 1; tick(2);
        rst = 1; tick(1);
        rst = 0; instr_read = 0; tick(1);
        instr_resp = 1; tick(1);
        idle_inputs(); tick(1);
        for (int i = 0; i < 8; i++) lit($sformatf("midrst ctr%0d", i), i, 0, 0);

        // Random traffic checked cycle-by-cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 299) == 0);
            instr_read    = ($urandom_range(0, 3) != 0);
            instr_resp    = ($urandom_range(0, 2) == 0);
            data_read     = ($urandom_range(0, 2) == 0);
            data_write    = ($urandom_range(0, 3) == 0);
            data_resp     = ($urandom_range(0, 2) == 0);
            l1_read       = ($urandom_range(0, 3) == 0);
            l1_write      = ($urandom_range(0, 5) == 0);
            l1_resp       = ($urandom_range(0, 3) == 0);
            br_valid      = ($urandom_range(0, 1) == 0);
            br_mispredict = ($urandom_range(0, 2) == 0);
            pipe_advance  = ($urandom_range(0, 3) != 0);
            ctr_store     = ($urandom_range(0, 15) == 0);
            ctr_addr      = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
            tick(1);
        end
        idle_inputs();
        rst = 0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
